// File: rtl/i2c_reg_master.sv
// i2c_reg_master
// Runs one single-byte I2C register transaction (write or read) to a fixed
// slave address. The request is launched by a rising edge on 'start' and
// reported back through per-direction completion flags.
//
// Optional feature: define I2C_ACK_CHECK_EN to abort on a slave NACK and
// report it on ack_err. Without it, ACK bits are ignored and ack_err is 0.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   start           level; a 0->1 transition launches a transaction
//   ADDR, DATA_IN   register sub-address (7 b) and write byte
//   R_W             1 = write, 0 = read
//   DATA_OUT        byte returned by the last read
//   flag_W, flag_R  last write / read completed
//   busy            transaction in progress
//   ack_err         slave NACK seen (feature-dependent)
//   scl, sda        I2C clock (push-pull, idles high) and open-drain data
module i2c_reg_master #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h1E,
    parameter int unsigned CLK_DIV    = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] ADDR,
    input  logic [7:0] DATA_IN,
    input  logic       R_W,
    output logic [7:0] DATA_OUT,
    output logic       flag_W,
    output logic       flag_R,
    output logic       busy,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, TX_BYTE, TX_ACK, RESTART, RX_BYTE, RX_NACK, STOP, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [1:0]        quarter_q, quarter_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_sel_q, byte_sel_d;
    logic [6:0]        addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              flag_w_q, flag_w_d;
    logic              flag_r_q, flag_r_d;
    logic              start_q;
    logic              sda_meta_q, sda_sync_q;
    logic              scl_q, scl_d;
    logic              sda_low_q, sda_low_d;
    logic [7:0]        tx_byte;
    logic              start_rise, quarter_end, sample, bit_end;
`ifdef I2C_ACK_CHECK_EN
    logic              nack_q, nack_d;
    logic              abort_q, abort_d;
    logic              ack_err_q, ack_err_d;
`endif

    assign start_rise  = start & ~start_q;
    assign quarter_end = (tick_q == TICK_MAX);
    // sda is sampled on the last clock of q2, while scl has been high a while
    assign sample      = quarter_end && (quarter_q == 2'd2);
    assign bit_end     = quarter_end && (quarter_q == 2'd3);

    // Byte currently being shifted out: address+W, sub-address, data, address+R
    always_comb begin
        case (byte_sel_q)
            2'd0:    tx_byte = {SLAVE_ADDR, 1'b0};
            2'd1:    tx_byte = {1'b0, addr_q};
            2'd2:    tx_byte = wdata_q;
            default: tx_byte = {SLAVE_ADDR, 1'b1};
        endcase
    end

    // State register; the edge detector is primed with the live start level
    // so a start already high at reset release does not launch a transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            quarter_q  <= '0;
            bit_cnt_q  <= '0;
            byte_sel_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            rx_shift_q <= '0;
            data_out_q <= '0;
            flag_w_q   <= 1'b0;
            flag_r_q   <= 1'b0;
            start_q    <= start;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
`ifdef I2C_ACK_CHECK_EN
            nack_q     <= 1'b0;
            abort_q    <= 1'b0;
            ack_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            quarter_q  <= quarter_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_sel_q <= byte_sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            rx_shift_q <= rx_shift_d;
            data_out_q <= data_out_d;
            flag_w_q   <= flag_w_d;
            flag_r_q   <= flag_r_d;
            start_q    <= start;
            sda_meta_q <= sda;
            sda_sync_q <= sda_meta_q;
            scl_q      <= scl_d;
            sda_low_q  <= sda_low_d;
`ifdef I2C_ACK_CHECK_EN
            nack_q     <= nack_d;
            abort_q    <= abort_d;
            ack_err_q  <= ack_err_d;
`endif
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        quarter_d  = quarter_q;
        bit_cnt_d  = bit_cnt_q;
        byte_sel_d = byte_sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        rx_shift_d = rx_shift_q;
        data_out_d = data_out_q;
        flag_w_d   = flag_w_q;
        flag_r_d   = flag_r_q;
`ifdef I2C_ACK_CHECK_EN
        nack_d     = nack_q;
        abort_d    = abort_q;
        ack_err_d  = ack_err_q;
`endif

        if (state_q != IDLE && state_q != DONE) begin
            if (quarter_end) begin
                tick_d    = '0;
                quarter_d = quarter_q + 2'd1;
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d    = START;
                    addr_d     = ADDR;
                    wdata_d    = DATA_IN;
                    rw_d       = R_W;
                    byte_sel_d = 2'd0;
                    flag_w_d   = 1'b0;
                    flag_r_d   = 1'b0;
`ifdef I2C_ACK_CHECK_EN
                    abort_d    = 1'b0;
                    ack_err_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (bit_end) state_d = TX_BYTE;
            end
            TX_BYTE: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = TX_ACK;
                end
            end
            TX_ACK: begin
`ifdef I2C_ACK_CHECK_EN
                if (sample) nack_d = sda_sync_q;
`endif
                if (bit_end) begin
                    case (byte_sel_q)
                        2'd0: begin
                            byte_sel_d = 2'd1;
                            state_d    = TX_BYTE;
                        end
                        2'd1: begin
                            if (rw_q) begin
                                byte_sel_d = 2'd2;
                                state_d    = TX_BYTE;
                            end else begin
                                state_d = RESTART;
                            end
                        end
                        2'd2:    state_d = STOP;
                        default: state_d = RX_BYTE;
                    endcase
`ifdef I2C_ACK_CHECK_EN
                    if (nack_q) begin
                        abort_d = 1'b1;
                        state_d = STOP;
                    end
`endif
                end
            end
            // Two bit periods: release and raise scl, then the repeated START
            RESTART: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd1) begin
                        byte_sel_d = 2'd3;
                        state_d    = TX_BYTE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            RX_BYTE: begin
                if (sample) rx_shift_d = {rx_shift_q[6:0], sda_sync_q};
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_NACK;
                end
            end
            RX_NACK: begin
                if (bit_end) state_d = STOP;
            end
            // Completion results are registered on the edge that enters DONE,
            // so flag and busy change together.
            STOP: begin
                if (bit_end) begin
                    state_d = DONE;
`ifdef I2C_ACK_CHECK_EN
                    if (abort_q) begin
                        ack_err_d = 1'b1;
                    end else
`endif
                    if (rw_q) begin
                        flag_w_d = 1'b1;
                    end else begin
                        flag_r_d   = 1'b1;
                        data_out_d = rx_shift_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            tick_d    = '0;
            quarter_d = '0;
            bit_cnt_d = '0;
        end
    end

    // Bus waveform per state and quarter; registered to keep scl/sda glitch-free
    always_comb begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        case (state_q)
            START: begin
                scl_d     = (quarter_q != 2'd3);
                sda_low_d = quarter_q[1];
            end
            TX_BYTE: begin
                scl_d     = quarter_q[0] ^ quarter_q[1];
                sda_low_d = ~tx_byte[3'd7 - bit_cnt_q];
            end
            TX_ACK, RX_BYTE, RX_NACK: begin
                scl_d = quarter_q[0] ^ quarter_q[1];
            end
            RESTART: begin
                if (bit_cnt_q == 3'd0) begin
                    scl_d = (quarter_q != 2'd0);
                end else begin
                    scl_d     = (quarter_q != 2'd3);
                    sda_low_d = (quarter_q != 2'd0);
                end
            end
            STOP: begin
                scl_d     = (quarter_q != 2'd0);
                sda_low_d = (quarter_q != 2'd3);
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign scl      = scl_q;
    assign sda      = sda_low_q ? 1'b0 : 1'bz;
    assign DATA_OUT = data_out_q;
    assign flag_W   = flag_w_q;
    assign flag_R   = flag_r_q;
`ifdef I2C_ACK_CHECK_EN
    assign ack_err  = ack_err_q;
`else
    assign ack_err  = 1'b0;
`endif

endmodule
